// File: rtl/psum_accumulator_pkg.sv
// Shared constants, state encoding and adder helpers for psum_accumulator.
// PSUM_SAT_EN selects clamping instead of two's-complement wrap.
package psum_accumulator_pkg;

  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int PROD_W = 16;
  localparam int PSUM_W = 21;

`ifdef PSUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    FLUSH,
    DRAIN,
    CLEAR
  } state_t;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [PSUM_W:0]   wide_t;

  // One guard bit above PSUM_W so overflow is visible as bit disagreement
  function automatic wide_t sext_add(
    input psum_t                    a,
    input logic signed [PROD_W-1:0] p
  );
    return {a[PSUM_W-1], a} +
           {{(PSUM_W+1-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic psum_t sat(input wide_t w);
    if (w[PSUM_W] != w[PSUM_W-1]) begin
      if (w[PSUM_W])
        return {1'b1, {(PSUM_W-1){1'b0}}};
      else
        return {1'b0, {(PSUM_W-1){1'b1}}};
    end
    return w[PSUM_W-1:0];
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Product input stream and drain output stream of psum_accumulator.
// Signal set is identical with or without PSUM_SAT_EN.
interface psum_accumulator_if;
  import psum_accumulator_pkg::*;

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic [IDX_W-1:0]  prod_idx;
  logic              prod_last;

  logic              out_valid;
  logic              out_ready;
  psum_t             out_data;
  logic [IDX_W-1:0]  out_idx;

  modport master (
    output prod_valid, prod_data, prod_idx, prod_last,
    output out_ready,
    input  prod_ready,
    input  out_valid, out_data, out_idx
  );

  modport slave (
    input  prod_valid, prod_data, prod_idx, prod_last,
    input  out_ready,
    output prod_ready,
    output out_valid, out_data, out_idx
  );

endinterface

// File: rtl/psum_accumulator_add_sat.sv
// Combinational psum + sign-extended product, with overflow flag.
// Clamps to the psum range when PSUM_SAT_EN is defined, else wraps.
module psum_add_sat
  import psum_accumulator_pkg::*;
(
  input  psum_t             operand,
  input  logic [PROD_W-1:0] prod,
  output psum_t             sum,
  output logic              ovf
);

  wide_t wide;

  assign wide = sext_add(operand, prod);
  assign ovf  = wide[PSUM_W] ^ wide[PSUM_W-1];

`ifdef PSUM_SAT_EN
  assign sum = sat(wide);
`else
  assign sum = wide[PSUM_W-1:0];
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Read-modify-write psum accumulator with ordered drain and clear.
// PSUM_SAT_EN enables clamping and the sticky sat_flag.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  psum_accumulator_if.slave bus,
  output logic [IDX_W-1:0]  spad_rd_idx,
  input  psum_t             spad_rd_data,
  output logic              spad_wr_en,
  output logic [IDX_W-1:0]  spad_wr_idx,
  output psum_t             spad_wr_data,
  output logic              spad_clear,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  state_t           state;
  state_t           next;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  psum_t            s1_sum;
  logic [IDX_W-1:0] drain_idx;

  logic  accept;
  logic  drain_hs;
  logic  fwd;
  psum_t operand;
  psum_t sum;
  logic  ovf;

  assign accept   = (state == ACC) & bus.prod_valid;
  assign drain_hs = (state == DRAIN) & bus.out_ready;

  // Stage-1 sum is not yet in the spad; bypass it for same-index hits
  assign fwd     = s1_valid & (s1_idx == bus.prod_idx);
  assign operand = fwd ? s1_sum : spad_rd_data;

  psum_add_sat u_add (
    .operand (operand),
    .prod    (bus.prod_data),
    .sum     (sum),
    .ovf     (ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_sum    <= '0;
      drain_idx <= '0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= next;
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= bus.prod_idx;
        s1_sum <= sum;
      end
      if (state == CLEAR)
        drain_idx <= '0;
      else if (drain_hs)
        drain_idx <= drain_idx + IDX_W'(1);
      if (state == IDLE && start)
        sat_flag <= 1'b0;
      else if (accept && ovf && SAT_EN)
        sat_flag <= 1'b1;
      done <= (state == CLEAR);
    end
  end

  always_comb begin
    next           = state;
    spad_rd_idx    = bus.prod_idx;
    bus.prod_ready = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_idx    = drain_idx;
    spad_clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          next = ACC;
      end
      ACC: begin
        bus.prod_ready = 1'b1;
        if (accept && bus.prod_last)
          next = FLUSH;
      end
      FLUSH: begin
        next = DRAIN;
      end
      DRAIN: begin
        spad_rd_idx   = drain_idx;
        bus.out_valid = 1'b1;
        bus.out_data  = spad_rd_data;
        if (drain_hs && drain_idx == IDX_W'(DEPTH-1))
          next = CLEAR;
      end
      CLEAR: begin
        spad_clear = ~reset;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign spad_wr_en   = s1_valid & ~reset;
  assign spad_wr_idx  = s1_idx;
  assign spad_wr_data = s1_sum;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a behavioural psum spad.
// Expected saturation results follow PSUM_SAT_EN.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  logic             clock;
  logic             reset;
  logic             start;
  logic [IDX_W-1:0] spad_rd_idx;
  psum_t            spad_rd_data;
  logic             spad_wr_en;
  logic [IDX_W-1:0] spad_wr_idx;
  psum_t            spad_wr_data;
  logic             spad_clear;
  logic             busy;
  logic             done;
  logic             sat_flag;

  logic             pre_en;
  logic [IDX_W-1:0] pre_idx;
  psum_t            pre_val;

  psum_accumulator_if bus ();

  psum_accumulator dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .spad_rd_idx  (spad_rd_idx),
    .spad_rd_data (spad_rd_data),
    .spad_wr_en   (spad_wr_en),
    .spad_wr_idx  (spad_wr_idx),
    .spad_wr_data (spad_wr_data),
    .spad_clear   (spad_clear),
    .busy         (busy),
    .done         (done),
    .sat_flag     (sat_flag)
  );

  psum_t spad_mem [DEPTH];
  psum_t m [DEPTH];

  assign spad_rd_data = spad_mem[spad_rd_idx];

  always @(posedge clock) begin
    if (reset || spad_clear) begin
      for (int k = 0; k < DEPTH; k++)
        spad_mem[k] <= '0;
    end else begin
      if (pre_en)
        spad_mem[pre_idx] <= pre_val;
      if (spad_wr_en)
        spad_mem[spad_wr_idx] <= spad_wr_data;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [IDX_W-1:0]         idx;
    logic signed [PROD_W-1:0] data;
    bit                       last;
    bit                       gap;
    bit                       start_too;
    psum_t                    exp;
  } vec_t;

  vec_t vt [14];
  int   checks   = 0;
  int   failures = 0;

`ifdef PSUM_SAT_EN
  localparam int  SAT_EXP  = 1048575;
  localparam bit  SAT_FLAG = 1'b1;
`else
  localparam int  SAT_EXP  = -1015810;
  localparam bit  SAT_FLAG = 1'b0;
`endif

  function automatic vec_t mk(int idx, int data, bit last,
                              bit gap, bit st, int exp);
    vec_t v;
    v.idx       = IDX_W'(idx);
    v.data      = PROD_W'(data);
    v.last      = last;
    v.gap       = gap;
    v.start_too = st;
    v.exp       = PSUM_W'(exp);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic feed(input int first, input int n);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("sat_cleared_by_start", sat_flag, 0);
    for (int k = 0; k < DEPTH; k++)
      m[k] = '0;
    for (int i = first; i < first + n; i++) begin
      if (vt[i].gap) begin
        bus.prod_valid = 1'b0;
        @(negedge clock);
        chk("gap_no_write", spad_wr_en, 0);
      end
      bus.prod_valid = 1'b1;
      bus.prod_idx   = vt[i].idx;
      bus.prod_data  = vt[i].data;
      bus.prod_last  = vt[i].last;
      start          = vt[i].start_too;
      chk("ready_in_acc", bus.prod_ready, 1);
      @(negedge clock);
      start = 1'b0;
      chk("wr_en", spad_wr_en, 1);
      chk("wr_idx", spad_wr_idx, vt[i].idx);
      chk("wr_data", spad_wr_data, vt[i].exp);
      m[vt[i].idx] = vt[i].exp;
    end
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    chk("flush_not_ready", bus.prod_ready, 0);
    chk("flush_busy", busy, 1);
  endtask

  task automatic drain(input bit [3:0] rpat, input int abort_at);
    int    cnt;
    int    k;
    int    budget;
    bit    held;
    psum_t hd;
    logic [IDX_W-1:0] hi;
    int    nz;
    cnt    = 0;
    k      = 0;
    budget = 400;
    held   = 1'b0;
    hd     = '0;
    hi     = '0;
    while (cnt < DEPTH && budget > 0) begin
      @(negedge clock);
      budget--;
      chk("drain_valid", bus.out_valid, 1);
      if (held) begin
        chk("stall_data_stable", bus.out_data, hd);
        chk("stall_idx_stable", bus.out_idx, hi);
      end
      if (abort_at == cnt) begin
        chk("abort_idx", bus.out_idx, cnt);
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        return;
      end
      bus.out_ready = rpat[k % 4];
      k++;
      if (bus.out_ready) begin
        chk("drain_idx", bus.out_idx, cnt);
        chk("drain_data", bus.out_data, m[cnt]);
        cnt++;
        held = 1'b0;
      end else begin
        hd   = bus.out_data;
        hi   = bus.out_idx;
        held = 1'b1;
      end
    end
    if (cnt < DEPTH)
      chk("drain_timeout", cnt, DEPTH);
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("clear_pulse", spad_clear, 1);
    chk("clear_no_valid", bus.out_valid, 0);
    chk("clear_busy", busy, 1);
    @(negedge clock);
    chk("done_pulse", done, 1);
    chk("idle_not_busy", busy, 0);
    chk("clear_one_cycle", spad_clear, 0);
    nz = 0;
    for (int j = 0; j < DEPTH; j++)
      if (spad_mem[j] != '0)
        nz++;
    chk("spad_cleared", nz, 0);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(3, 5, 0, 0, 0, 5);
    vt[1]  = mk(3, -2, 0, 0, 0, 3);
    vt[2]  = mk(0, 7, 0, 0, 0, 7);
    vt[3]  = mk(0, -2, 1, 0, 0, 5);
    vt[4]  = mk(7, 100, 0, 0, 0, 100);
    vt[5]  = mk(7, 100, 0, 0, 1, 200);
    vt[6]  = mk(7, 100, 0, 0, 0, 300);
    vt[7]  = mk(7, 100, 1, 0, 0, 400);
    vt[8]  = mk(31, 1000, 0, 0, 0, 1000);
    vt[9]  = mk(31, -3000, 0, 1, 0, -2000);
    vt[10] = mk(2, 32767, 0, 0, 0, 32767);
    vt[11] = mk(2, -32768, 1, 0, 0, -1);
    vt[12] = mk(1, 32767, 1, 0, 0, SAT_EXP);
    vt[13] = mk(10, 9, 1, 0, 0, 9);

    reset          = 1'b1;
    start          = 1'b0;
    pre_en         = 1'b0;
    pre_idx        = '0;
    pre_val        = '0;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.prod_idx   = '0;
    bus.prod_last  = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_prod_ready", bus.prod_ready, 0);
    chk("rst_wr_en", spad_wr_en, 0);
    chk("rst_clear", spad_clear, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    reset = 1'b0;

    bus.prod_valid = 1'b1;
    bus.prod_idx   = 5'd4;
    bus.prod_data  = 16'sd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("idle_not_ready", bus.prod_ready, 0);
      chk("idle_no_write", spad_wr_en, 0);
    end
    bus.prod_valid = 1'b0;
    chk("idle_entry_untouched", spad_mem[4], 0);

    feed(0, 4);
    drain(4'b1111, -1);
    feed(4, 4);
    drain(4'b1111, -1);
    feed(8, 4);
    drain(4'b1001, -1);

    @(negedge clock);
    pre_en  = 1'b1;
    pre_idx = 5'd1;
    pre_val = 21'sd1048575;
    @(negedge clock);
    pre_en = 1'b0;
    feed(12, 1);
    chk("sat_flag_set", sat_flag, SAT_FLAG);
    drain(4'b1111, -1);
    chk("sat_flag_sticky", sat_flag, SAT_FLAG);

    feed(13, 1);
    drain(4'b1111, 10);
    @(negedge clock);
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_clear", spad_clear, 0);
    chk("rst_mid_wr", spad_wr_en, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_done", done, 0);
    chk("post_rst_idle", busy, 0);

    feed(0, 4);
    drain(4'b1001, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
